// File: rtl/keeper_round_ctrl.sv
`default_nettype none
// ============================================================================
// keeper_round_ctrl : goalkeeper round sequencer (shot over UART, save/goal
//                     decision, target-box overlay on the video stream)
// Revision          : 1.0
// ============================================================================
module keeper_round_ctrl #(
  parameter int TGT_W        = 100,
  parameter int TGT_H        = 100,
  parameter int ENGAGE_TICKS = 65_000_000,
  parameter int COUNT_TICKS  = 65_000_000,
  parameter int SHOW_TICKS   = 13_000_000,
  parameter int CNT_W        = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keeper_en,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [9:0]  shot_xpos,
  input  logic [9:0]  shot_ypos,
  input  logic        tx_full,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [11:0] rgb_in,
  output logic [11:0] rgb_out,
  output logic        is_scored,
  output logic        round_done,
  output logic        end_gk
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_ENGAGE    = 3'd2;
  localparam logic [2:0] S_COUNTDOWN = 3'd3;
  localparam logic [2:0] S_RESULT    = 3'd4;
  localparam logic [2:0] S_SHOW      = 3'd5;
  localparam logic [2:0] S_TERMINATE = 3'd6;

  localparam logic [12:0]      c_W_M1     = 13'(TGT_W - 1);
  localparam logic [12:0]      c_H_M1     = 13'(TGT_H - 1);
  localparam logic [CNT_W-1:0] c_ENG_LAST = CNT_W'(ENGAGE_TICKS - 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(COUNT_TICKS - 1);
  localparam logic [CNT_W-1:0] c_SHW_LAST = CNT_W'(SHOW_TICKS - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       idx_q, idx_d;
  logic [9:0]       sx_q, sx_d, sy_q, sy_d;
  logic             scored_q, scored_d;
  logic [11:0]      rgb_q, rgb_d;

  logic [12:0] w_sx, w_sy;
  logic        w_glove_in, w_pix_in;
  logic [7:0]  w_byte;

  // 13-bit bounds so a box near the 1023 edge never wraps to low coordinates
  assign w_sx = {3'b000, sx_q};
  assign w_sy = {3'b000, sy_q};
  assign w_glove_in = ({1'b0, xpos} >= w_sx) && ({1'b0, xpos} <= w_sx + c_W_M1) &&
                      ({1'b0, ypos} >= w_sy) && ({1'b0, ypos} <= w_sy + c_H_M1);
  assign w_pix_in   = ({2'b00, hcount} >= w_sx) && ({2'b00, hcount} <= w_sx + c_W_M1) &&
                      ({2'b00, vcount} >= w_sy) && ({2'b00, vcount} <= w_sy + c_H_M1);

  assign w_byte = (idx_q == 2'd0) ? {sx_q[4:0], 3'b001} :
                  (idx_q == 2'd1) ? {sx_q[9:5], 3'b010} :
                  (idx_q == 2'd2) ? {sy_q[4:0], 3'b101} :
                                    {sy_q[9:5], 3'b110};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= 2'd0;
      sx_q     <= 10'd0;
      sy_q     <= 10'd0;
      scored_q <= 1'b0;
      rgb_q    <= 12'h000;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      scored_q <= scored_d;
      rgb_q    <= rgb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    scored_d = scored_q;
    case (state_q)
      S_IDLE: begin
        if (keeper_en) begin
          state_d  = S_SEND;
          sx_d     = shot_xpos;
          sy_d     = shot_ypos;
          scored_d = 1'b0;
          idx_d    = 2'd0;
          timer_d  = '0;
        end
      end
      S_SEND: begin
        if (!keeper_en) begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          timer_d = '0;
        end else if (!tx_full) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_ENGAGE;
            timer_d = '0;
          end
        end
      end
      S_ENGAGE: begin
        if (!keeper_en) begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          timer_d = '0;
        end else if (timer_q == c_ENG_LAST) begin
          state_d = S_COUNTDOWN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + c_ONE;
        end
      end
      S_COUNTDOWN: begin
        if (timer_q == c_CNT_LAST) begin
          state_d = S_RESULT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + c_ONE;
        end
      end
      S_RESULT: begin
        state_d  = S_SHOW;
        timer_d  = '0;
        scored_d = !w_glove_in;
      end
      S_SHOW: begin
        if (timer_q == c_SHW_LAST) begin
          state_d = S_TERMINATE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + c_ONE;
        end
      end
      S_TERMINATE: state_d = S_IDLE;
      default: begin
        state_d  = S_IDLE;
        timer_d  = '0;
        idx_d    = 2'd0;
        sx_d     = 10'd0;
        sy_d     = 10'd0;
        scored_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_wr      = 1'b0;
    tx_data    = 8'h00;
    round_done = 1'b0;
    end_gk     = 1'b0;
    rgb_d      = rgb_in;
    case (state_q)
      S_SEND: begin
        tx_data = w_byte;
        tx_wr   = rst && keeper_en && !tx_full;
      end
      S_COUNTDOWN: if (w_pix_in) rgb_d = 12'h00F;
      S_SHOW: begin
        if (w_pix_in) rgb_d = scored_q ? 12'hF00 : 12'h0F0;
        round_done = (timer_q == c_SHW_LAST);
      end
      S_TERMINATE: end_gk = 1'b1;
      S_IDLE, S_ENGAGE, S_RESULT: ;
      default: rgb_d = 12'h000;
    endcase
  end

  assign rgb_out   = rgb_q;
  assign is_scored = scored_q;

endmodule
`default_nettype wire

// File: tb/tb_keeper_round_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keeper_round_ctrl : scoreboard bench for keeper_round_ctrl
// Revision             : 1.0
// ============================================================================
module tb_keeper_round_ctrl;
  localparam int TGT_W = 4;
  localparam int TGT_H = 4;
  localparam int ENG   = 3;
  localparam int CNT   = 5;
  localparam int SHW   = 2;

  logic        clk = 1'b0, rst = 1'b0, keeper_en = 1'b0, tx_full = 1'b0;
  logic [11:0] xpos = '0, ypos = '0;
  logic [9:0]  shot_xpos = '0, shot_ypos = '0;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic [10:0] hcount = '0, vcount = '0;
  logic [11:0] rgb_in = 12'hABC;
  logic [11:0] rgb_out;
  logic        is_scored, round_done, end_gk;

  keeper_round_ctrl #(
    .TGT_W(TGT_W), .TGT_H(TGT_H), .ENGAGE_TICKS(ENG), .COUNT_TICKS(CNT),
    .SHOW_TICKS(SHW), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .keeper_en(keeper_en), .xpos(xpos), .ypos(ypos),
    .shot_xpos(shot_xpos), .shot_ypos(shot_ypos), .tx_full(tx_full),
    .tx_wr(tx_wr), .tx_data(tx_data), .hcount(hcount), .vcount(vcount),
    .rgb_in(rgb_in), .rgb_out(rgb_out), .is_scored(is_scored),
    .round_done(round_done), .end_gk(end_gk)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] byte_q[$];
  logic       goal_q[$];
  int cyc = 0, last_tx_cyc = 0, rd_cyc = -100, n_tx = 0, n_rd = 0, n_eg = 0;
  logic mon_goal;

  // Output monitor: pops expected bytes and round outcomes as the DUT emits them
  always @(negedge clk) begin
    cyc++;
    if (tx_wr) begin
      check("tx_wr_while_full", {31'b0, tx_full}, 32'd0);
      if (byte_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else check("tx_byte", {24'b0, tx_data}, {24'b0, byte_q.pop_front()});
      last_tx_cyc = cyc;
      n_tx++;
    end
    if (round_done) begin
      n_rd++;
      rd_cyc = cyc;
      if (goal_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else begin
        mon_goal = goal_q.pop_front();
        check("rd_after_last_byte", cyc - last_tx_cyc, 32'd11);
        check("show_colour", {20'b0, rgb_out}, mon_goal ? 32'hF00 : 32'h0F0);
        check("is_scored_show", {31'b0, is_scored}, {31'b0, mon_goal});
      end
    end
    if (end_gk) begin
      n_eg++;
      check("end_gk_after_rd", cyc - rd_cyc, 32'd1);
    end
  end

  task automatic wait_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [9:0] sx, input logic [9:0] sy, input int n);
    logic [7:0] b[4];
    b[0] = {sx[4:0], 3'b001};
    b[1] = {sx[9:5], 3'b010};
    b[2] = {sy[4:0], 3'b101};
    b[3] = {sy[9:5], 3'b110};
    for (int i = 0; i < n; i++) byte_q.push_back(b[i]);
  endtask

  task automatic run_round(input logic [9:0] sx, input logic [9:0] sy,
                           input logic [11:0] gx, input logic [11:0] gy,
                           input int stall_len, input bit cd_drop);
    int n0, rd0, eg0, t;
    bit save;
    save = (int'(gx) >= int'(sx)) && (int'(gx) <= int'(sx) + TGT_W - 1) &&
           (int'(gy) >= int'(sy)) && (int'(gy) <= int'(sy) + TGT_H - 1);
    shot_xpos = sx; shot_ypos = sy; xpos = gx; ypos = gy;
    hcount = {1'b0, sx}; vcount = {1'b0, sy};
    push_bytes(sx, sy, 4);
    goal_q.push_back(!save);
    n0 = n_tx; rd0 = n_rd; eg0 = n_eg;
    keeper_en = 1'b1;
    if (stall_len > 0) begin
      t = 0;
      while (n_tx == n0 && t < 20) begin wait_cyc(); t++; end
      tx_full = 1'b1;
      repeat (stall_len) wait_cyc();
      check("stall_holds_tx", n_tx - n0, 32'd1);
      tx_full = 1'b0;
    end
    t = 0;
    while (n_tx - n0 < 4 && t < 40) begin wait_cyc(); t++; end
    check("send_four", n_tx - n0, 32'd4);
    t = 0;
    while (cyc < last_tx_cyc + 6 && t < 20) begin wait_cyc(); t++; end
    check("cd_colour", {20'b0, rgb_out}, 32'h00F);
    hcount = 11'(int'(sx) + TGT_W);
    if (cd_drop) keeper_en = 1'b0;
    wait_cyc();
    check("cd_outside", {20'b0, rgb_out}, {20'b0, rgb_in});
    hcount = {1'b0, sx};
    t = 0;
    while (n_rd == rd0 && t < 40) begin wait_cyc(); t++; end
    keeper_en = 1'b0;
    t = 0;
    while (n_eg == eg0 && t < 10) begin wait_cyc(); t++; end
    repeat (3) wait_cyc();
    check("rd_once", n_rd - rd0, 32'd1);
    check("eg_once", n_eg - eg0, 32'd1);
    check("is_scored_held", {31'b0, is_scored}, {31'b0, !save});
    check("no_extra_tx", n_tx - n0, 32'd4);
  endtask

  initial begin
    int n0, rd0, eg0, t;
    repeat (3) wait_cyc();
    check("rst_tx_wr", {31'b0, tx_wr}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_rgb", {20'b0, rgb_out}, 32'd0);
    check("rst_flags", {29'b0, is_scored, round_done, end_gk}, 32'd0);
    rst = 1'b1;
    repeat (2) wait_cyc();
    check("rgb_passthru", {20'b0, rgb_out}, 32'hABC);

    run_round(10'h2A3, 10'h155, 12'd0, 12'd0, 0, 1'b0);
    run_round(10'h2A3, 10'h155, 12'h2A4, 12'h156, 10, 1'b0);
    run_round(10'd100, 10'd100, 12'd103, 12'd103, 0, 1'b0);
    run_round(10'd100, 10'd100, 12'd104, 12'd100, 0, 1'b0);
    run_round(10'd1020, 10'd1020, 12'd1023, 12'd1020, 0, 1'b0);
    run_round(10'd1020, 10'd1020, 12'd0, 12'd1020, 0, 1'b0);

    // Reset in IDLE clears a held goal result
    rst = 1'b0; wait_cyc();
    check("rst_clears_scored", {31'b0, is_scored}, 32'd0);
    rst = 1'b1; wait_cyc();

    run_round(10'd50, 10'd60, 12'd51, 12'd61, 0, 1'b1);

    // keeper_en drop during ENGAGE aborts the round
    shot_xpos = 10'd300; shot_ypos = 10'd200;
    push_bytes(10'd300, 10'd200, 4);
    n0 = n_tx; rd0 = n_rd; eg0 = n_eg; keeper_en = 1'b1;
    t = 0;
    while (n_tx - n0 < 4 && t < 40) begin wait_cyc(); t++; end
    wait_cyc();
    keeper_en = 1'b0;
    repeat (20) wait_cyc();
    check("eng_abort_tx", n_tx - n0, 32'd4);
    check("eng_abort_no_rd", n_rd - rd0, 32'd0);
    check("eng_abort_no_eg", n_eg - eg0, 32'd0);

    // keeper_en drop during SEND stops further bytes
    shot_xpos = 10'd77; shot_ypos = 10'd99;
    push_bytes(10'd77, 10'd99, 1);
    n0 = n_tx; keeper_en = 1'b1;
    t = 0;
    while (n_tx == n0 && t < 20) begin wait_cyc(); t++; end
    keeper_en = 1'b0;
    repeat (10) wait_cyc();
    check("send_abort_tx", n_tx - n0, 32'd1);

    // Reset mid-SEND drops the remaining bytes
    shot_xpos = 10'd511; shot_ypos = 10'd3;
    push_bytes(10'd511, 10'd3, 1);
    n0 = n_tx; keeper_en = 1'b1;
    t = 0;
    while (n_tx == n0 && t < 20) begin wait_cyc(); t++; end
    rst = 1'b0;
    wait_cyc();
    check("rst_send_tx_wr", {31'b0, tx_wr}, 32'd0);
    check("rst_send_data", {24'b0, tx_data}, 32'd0);
    check("rst_send_rgb", {20'b0, rgb_out}, 32'd0);
    rst = 1'b1; keeper_en = 1'b0;
    repeat (8) wait_cyc();
    check("rst_send_drop", n_tx - n0, 32'd1);

    run_round(10'd5, 10'd7, 12'd5, 12'd7, 0, 1'b0);

    check("byte_q_drained", byte_q.size(), 32'd0);
    check("goal_q_drained", goal_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
